rng_latch_sequencer: RTL and testbench
======================================

Name: rng_latch_sequencer

Overview:
- Controller that sequences the latch-based entropy array inside tt_um_random_latch.
- Arms the latch cells, waits for them to resolve, samples and XOR-folds their outputs into one raw bit per cycle of the sequence.
- Optionally applies von Neumann debiasing, packs bits into bytes and presents them on a valid/ready port.
- Runs a repetition-count health check that latches a sticky fault.

Parameters:
- N_CELLS, 8: number of latch cells driven and sampled.
- ARM_CYCLES, 2: cycles latch_arm is held high per sample; must be ≥1.
- SETTLE_CYCLES, 4: cycles waited after arm release before sampling; must be ≥2 to cover the synchronizer.
- REP_LIMIT, 16: consecutive identical raw bits that trip the fault; must be ≥2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- ena  input  1  design enable; low forces IDLE
- run  input  1  level request to generate bytes continuously
- debias_en  input  1  1 = von Neumann debiasing on
- clear_fault  input  1  one-cycle pulse that clears fault
- latch_bits  input  N_CELLS  raw latch cell outputs (asynchronous)
- latch_arm  output  1  high = force cells into the metastable/reset phase
- out_data  output  8  assembled random byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts byte
- fault  output  1  sticky health-check failure
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - Outputs: state=IDLE; latch_arm=0, out_data=0, out_valid=0, fault=0, busy=0.
  - Internals: bit count, pair register, repetition counter and synchronizer cleared.
- Synchronizer: latch_bits passes through a 2-flop synchronizer every cycle. The raw bit is the XOR of all synced bits.
- FSM states: IDLE, ARM, SETTLE, SAMPLE, HOLD.
  - IDLE: if ena & run & !fault, go to ARM. At this edge, latch debias_en into a byte-local mode bit, and clear the bit count and pair register.
  - ARM: latch_arm=1 for exactly ARM_CYCLES cycles, then SETTLE.
  - SETTLE: latch_arm=0 for SETTLE_CYCLES cycles, then SAMPLE.
  - SAMPLE: one cycle. On the exiting edge, capture raw bit r and update the repetition counter.
    - Debias off: shift r in.
    - Debias on, first of a pair: store r.
    - Debias on, second of a pair: if it differs from the stored bit, shift the stored bit in (10→1, 01→0); otherwise discard both. The pair register is cleared in either case.
    - Next state is HOLD if 8 bits have been accumulated, else ARM.
- Packing: shift left, new bit enters LSB, so the first accepted bit ends in out_data[7].
- HOLD:
  - out_valid=1; out_data stable; latch_arm=0.
  - On out_valid & out_ready: out_valid drops next cycle. Go to ARM (new byte, debias_en re-latched, counters cleared) if ena & run & !fault, else IDLE.
- Timing (debias off, default parameters):
  - 7 cycles per sample.
  - out_valid rises 56 edges after the edge at which IDLE sampled run=1.
  - Back-to-back bytes: 56 cycles from the handshake edge to the next out_valid.
- run deassertion: checked only in IDLE and at the HOLD handshake. A byte in progress always completes.
- Health check:
  - The repetition counter counts consecutive equal raw bits, starting at 1 on a change.
  - When it reaches REP_LIMIT, fault=1 on that edge. The FSM goes to IDLE from any state (including mid-byte and HOLD), the partial or held byte is discarded, and out_valid=0.
  - fault stays set until a clear_fault pulse. The clear also zeroes the repetition counter.
  - If clear_fault and a new trip occur in the same cycle, set wins.
  - clear_fault while fault=0 has no effect.
- ena=0 in any state: next cycle state=IDLE, latch_arm=0, out_valid=0; partial byte, pair register and repetition counter cleared; fault retained.
- busy = (state != IDLE).

Test Plan:
- Debias off, bench flips the folded parity each sample (latch_bits alternates 8'h01/8'h00), run=1, out_ready=1 → out_data=8'hAA, out_valid first high 56 edges after start; latch_arm high 2 cycles out of every 7.
- Debias on, raw sequence 1,0 repeated 8 times → one byte 8'hFF after 16 samples. Raw pairs 11,00,01 ×3 then 01 ×5 → 8'h00, with 11/00 pairs discarded.
- Backpressure: out_ready=0 for 20 cycles in HOLD → out_valid and out_data stable, latch_arm=0, busy=1. After out_ready=1, exactly one transfer occurs.
- Fault: latch_bits=8'h00 constantly → fault=1 at the 16th SAMPLE edge, state IDLE, out_valid never asserts. A clear_fault pulse with run=1 restarts generation.
- Mid-byte abort: ena=0 after 3 samples → IDLE next cycle, latch_arm=0. Re-enable → full 8 fresh samples before out_valid; bits from the aborted byte are absent.
- Async reset asserted during ARM → latch_arm and all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rng_latch_sequencer.sv
// Sequencer for a latch-based entropy array: arms the cells, lets them resolve,
// folds the synchronized outputs into raw bits, optionally debiases, and packs bytes.
module rng_latch_sequencer #(
  parameter int N_CELLS       = 8,
  parameter int ARM_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int REP_LIMIT     = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               run,
  input  logic               debias_en,
  input  logic               clear_fault,
  input  logic [N_CELLS-1:0] latch_bits,
  output logic               latch_arm,
  output logic [7:0]         out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               fault,
  output logic               busy
);
  localparam int CNT_W = $clog2(ARM_CYCLES + SETTLE_CYCLES + 1);
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [CNT_W-1:0] ARM_LAST    = CNT_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ARM, SETTLE, SAMPLE, HOLD} state_t;

  state_t             state;
  logic [N_CELLS-1:0] sync_p0, sync_p1;
  logic [CNT_W-1:0]   cyc_cnt;
  logic [REP_W-1:0]   rep_cnt, rep_next;
  logic [3:0]         bit_cnt, cnt_next;
  logic [7:0]         byte_sr, sr_next;
  logic               mode_debias, pair_vld, pair_bit, last_raw;
  logic               raw_bit, take_bit, take_val, trip, start_byte;

  // A zero count means no history, so the next bit always restarts the run at 1.
  function automatic logic [REP_W-1:0] rep_step(input logic [REP_W-1:0] cnt,
                                                input logic same);
    if (same && cnt != '0) return cnt + REP_W'(1);
    return REP_W'(1);
  endfunction

  assign raw_bit = ^sync_p1;
  assign busy    = (state != IDLE);

  always_comb begin
    rep_next   = rep_step(rep_cnt, raw_bit == last_raw);
    trip       = (rep_next == REP_W'(REP_LIMIT));
    take_bit   = !mode_debias || (pair_vld && (raw_bit != pair_bit));
    take_val   = mode_debias ? pair_bit : raw_bit;
    sr_next    = {byte_sr[6:0], take_val};
    cnt_next   = bit_cnt + {3'b000, take_bit};
    start_byte = ena && run && !fault &&
                 ((state == IDLE) || (state == HOLD && out_ready));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sync_p0     <= '0;
      sync_p1     <= '0;
      cyc_cnt     <= '0;
      rep_cnt     <= '0;
      bit_cnt     <= '0;
      byte_sr     <= '0;
      mode_debias <= 1'b0;
      pair_vld    <= 1'b0;
      pair_bit    <= 1'b0;
      last_raw    <= 1'b0;
      latch_arm   <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      fault       <= 1'b0;
    end else begin
      // stage p0 -> p1: two-flop synchronizer on the asynchronous cell outputs
      sync_p0 <= latch_bits;
      sync_p1 <= sync_p0;

      if (clear_fault && fault) begin
        fault   <= 1'b0;
        rep_cnt <= '0;
      end

      if (!ena) begin
        state     <= IDLE;
        latch_arm <= 1'b0;
        out_valid <= 1'b0;
        cyc_cnt   <= '0;
        bit_cnt   <= '0;
        byte_sr   <= '0;
        pair_vld  <= 1'b0;
        pair_bit  <= 1'b0;
        rep_cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start_byte) begin
              state     <= ARM;
              latch_arm <= 1'b1;
              cyc_cnt   <= '0;
            end
          end
          ARM: begin
            if (cyc_cnt == ARM_LAST) begin
              state     <= SETTLE;
              latch_arm <= 1'b0;
              cyc_cnt   <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
          end
          SETTLE: begin
            if (cyc_cnt == SETTLE_LAST) begin
              state   <= SAMPLE;
              cyc_cnt <= '0;
            end else begin
              cyc_cnt <= cyc_cnt + CNT_W'(1);
            end
          end
          SAMPLE: begin
            last_raw <= raw_bit;
            rep_cnt  <= rep_next;
            if (mode_debias) begin
              pair_vld <= !pair_vld;
              pair_bit <= pair_vld ? 1'b0 : raw_bit;
            end
            if (take_bit) begin
              byte_sr <= sr_next;
              bit_cnt <= cnt_next;
            end
            // A health trip discards whatever part of the byte was gathered.
            if (trip) begin
              fault    <= 1'b1;
              state    <= IDLE;
              byte_sr  <= '0;
              bit_cnt  <= '0;
              pair_vld <= 1'b0;
              pair_bit <= 1'b0;
            end else if (cnt_next == 4'd8) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_data  <= sr_next;
            end else begin
              state     <= ARM;
              latch_arm <= 1'b1;
            end
          end
          HOLD: begin
            if (out_ready) begin
              out_valid <= 1'b0;
              if (start_byte) begin
                state     <= ARM;
                latch_arm <= 1'b1;
                cyc_cnt   <= '0;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: state <= IDLE;
        endcase

        if (start_byte) begin
          mode_debias <= debias_en;
          bit_cnt     <= '0;
          byte_sr     <= '0;
          pair_vld    <= 1'b0;
          pair_bit    <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_rng_latch_sequencer.sv
// Directed bench for rng_latch_sequencer: a pattern player drives latch_bits once
// per arm pulse, and each scenario task checks timing and bytes against hand values.
module tb_rng_latch_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0, run = 1'b0, debias_en = 1'b0, clear_fault = 1'b0;
  logic [7:0] latch_bits = 8'h00;
  logic       latch_arm, out_valid, fault, busy;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;

  int errors = 0;
  int checks = 0;

  logic [7:0] pat [0:31];
  int         pat_len = 1;
  int         pat_idx = 0;

  rng_latch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .run(run), .debias_en(debias_en),
    .clear_fault(clear_fault), .latch_bits(latch_bits), .latch_arm(latch_arm),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .fault(fault), .busy(busy)
  );

  initial forever #5 clk = ~clk;

  // Each arm pulse presents the next cell pattern; it is stable long before sampling.
  always @(posedge latch_arm) begin
    latch_bits = pat[pat_idx % pat_len];
    pat_idx    = pat_idx + 1;
  end

  task automatic load_bits(input logic [31:0] bits, input int len,
                           input logic [7:0] one_v, input logic [7:0] zero_v);
    for (int i = 0; i < len; i++) pat[i] = bits[len-1-i] ? one_v : zero_v;
    pat_len = len;
    pat_idx = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Counts negedges after the start edge until out_valid is seen (k = edges after start).
  task automatic wait_valid(input int limit, output int k, output int arm);
    k = 0; arm = 0;
    @(negedge clk);
    while (!out_valid && k < limit) begin
      if (latch_arm) arm++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    ena = 1'b1;
    checks++; if (latch_arm !== 1'b0) begin errors++; $display("FAIL reset_arm got=%b exp=0", latch_arm); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", fault); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int k, arm;
    load_bits(32'b10, 2, 8'h01, 8'h00);
    debias_en = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    run = 1'b1;
    wait_valid(200, k, arm);
    checks++; if (k !== 56) begin errors++; $display("FAIL basic_latency got=%0d exp=56", k); end
    checks++; if (arm !== 16) begin errors++; $display("FAIL basic_arm_cycles got=%0d exp=16", arm); end
    checks++; if (out_data !== 8'hAA) begin errors++; $display("FAIL basic_data got=%h exp=AA", out_data); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL b2b_after_hs valid=%b busy=%b exp valid=0 busy=1", out_valid, busy); end
    wait_valid(200, k, arm);
    // one negedge after the handshake edge was already consumed above
    checks++; if (k + 1 !== 56) begin errors++; $display("FAIL b2b_latency got=%0d exp=56", k + 1); end
    checks++; if (out_data !== 8'hAA) begin errors++; $display("FAIL b2b_data got=%h exp=AA", out_data); end
    run = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_stop busy=%b valid=%b exp 0 0", busy, out_valid); end
  endtask

  task automatic test_debias();
    int k, arm;
    load_bits(32'b10, 2, 8'h80, 8'hC0);
    debias_en = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    run = 1'b1;
    wait_valid(300, k, arm);
    checks++; if (k !== 112) begin errors++; $display("FAIL debias_ff_latency got=%0d exp=112", k); end
    checks++; if (out_data !== 8'hFF) begin errors++; $display("FAIL debias_ff_data got=%h exp=FF", out_data); end
    run = 1'b0;
    @(negedge clk);
    load_bits(32'b1100011100011100010101010101, 28, 8'h07, 8'h03);
    run = 1'b1;
    wait_valid(400, k, arm);
    checks++; if (k !== 196) begin errors++; $display("FAIL debias_00_latency got=%0d exp=196", k); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL debias_00_data got=%h exp=00", out_data); end
    run = 1'b0;
    @(negedge clk);
    debias_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int k, arm, extra;
    logic stable;
    load_bits(32'b01101001, 8, 8'h07, 8'h03);
    out_ready = 1'b0;
    @(negedge clk);
    run = 1'b1;
    wait_valid(200, k, arm);
    checks++; if (k !== 56 || out_data !== 8'h69) begin errors++; $display("FAIL bp_byte k=%0d data=%h exp k=56 data=69", k, out_data); end
    run = 1'b0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'h69 || latch_arm !== 1'b0 || busy !== 1'b1) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold_stable got=%b exp=1", stable); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release valid=%b busy=%b exp 0 0", out_valid, busy); end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL bp_single_transfer extra=%0d exp=0", extra); end
  endtask

  task automatic test_fault();
    int k;
    logic saw_valid, idle_ok;
    do_reset();
    load_bits(32'b0, 1, 8'h00, 8'h00);
    debias_en = 1'b1;
    @(negedge clk);
    run = 1'b1;
    k = 0; saw_valid = 1'b0;
    @(negedge clk);
    while (!fault && k < 300) begin
      if (out_valid) saw_valid = 1'b1;
      @(negedge clk);
      k++;
    end
    checks++; if (k !== 112) begin errors++; $display("FAIL fault_trip_edge got=%0d exp=112", k); end
    checks++; if (saw_valid !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL fault_no_valid got=%b exp=0", saw_valid | out_valid); end
    checks++; if (busy !== 1'b0 || latch_arm !== 1'b0) begin errors++; $display("FAIL fault_idle busy=%b arm=%b exp 0 0", busy, latch_arm); end
    idle_ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (fault !== 1'b1 || busy !== 1'b0) idle_ok = 1'b0;
    end
    checks++; if (idle_ok !== 1'b1) begin errors++; $display("FAIL fault_sticky got=%b exp=1", idle_ok); end
    load_bits(32'b10, 2, 8'h01, 8'h00);
    clear_fault = 1'b1;
    @(negedge clk);
    clear_fault = 1'b0;
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b exp=0", fault); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fault_restart busy=%b exp=1", busy); end
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1; run = 1'b0; debias_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_abort();
    int k, arm;
    load_bits(32'hFFFFFFFF, 8, 8'h01, 8'h00);
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    repeat (21) @(negedge clk);
    checks++; if (busy !== 1'b1 || latch_arm !== 1'b1) begin errors++; $display("FAIL abort_pre busy=%b arm=%b exp 1 1", busy, latch_arm); end
    ena = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || latch_arm !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b arm=%b valid=%b exp 0 0 0", busy, latch_arm, out_valid); end
    load_bits(32'b01011011, 8, 8'hE0, 8'h81);
    ena = 1'b1;
    wait_valid(200, k, arm);
    checks++; if (k !== 56) begin errors++; $display("FAIL abort_fresh_latency got=%0d exp=56", k); end
    checks++; if (out_data !== 8'h5B) begin errors++; $display("FAIL abort_fresh_data got=%h exp=5B", out_data); end
    run = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    int guard;
    @(negedge clk);
    run = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!latch_arm && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (latch_arm !== 1'b1) begin errors++; $display("FAIL areset_arm_pre got=%b exp=1", latch_arm); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (latch_arm !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00 || fault !== 1'b0)
      begin errors++; $display("FAIL areset_immediate arm=%b busy=%b valid=%b data=%h fault=%b exp all 0", latch_arm, busy, out_valid, out_data, fault); end
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    pat[0] = 8'h00;
    test_reset();
    test_basic();
    test_debias();
    test_backpressure();
    test_fault();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
